// File: rtl/sha_1_arbiter.sv
// -----------------------------------------------------------------------------
// sha_1_arbiter
// Round-robin arbiter/sequencer that shares one sha_1 core between NUM_REQ
// requesters. A granted requester's 512-bit block is latched and presented to
// the core, core_start is held for START_CYCLES, then the core's done rising
// edge returns the 160-bit digest. A watchdog aborts a hung core with resp_err.
//
// Ports
//   clk, reset_n   clock (rising edge), asynchronous active-low reset
//   req            level request per requester, held until its resp_valid
//   req_data       block for requester i at [i*512 +: 512]
//   gnt            one-hot pulse in the cycle after the block was latched
//   resp_valid     one-hot pulse, resp_digest/resp_err valid
//   resp_digest    H0 in [159:128] .. H4 in [31:0]; zero on timeout
//   resp_err       1 = job aborted by watchdog
//   busy           high in any state other than IDLE
//   core_start     sha_1 start, high for START_CYCLES per job
//   core_in_data   latched block, held from grant until the next grant
//   core_out_data  sha_1 digest
//   core_done      sha_1 done (completion is its rising edge while waiting)
// -----------------------------------------------------------------------------
module sha_1_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned START_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*512-1:0] req_data,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [159:0]           resp_digest,
    output logic                   resp_err,
    output logic                   busy,
    output logic                   core_start,
    output logic [511:0]           core_in_data,
    input  logic [159:0]           core_out_data,
    input  logic                   core_done
);

    localparam int unsigned PW   = $clog2(NUM_REQ);
    localparam int unsigned CMAX = (TIMEOUT_CYCLES > START_CYCLES) ? TIMEOUT_CYCLES : START_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } state_e;

    state_e                   state_q, state_d;
    logic [PW-1:0]            rr_q, rr_d;
    logic [PW-1:0]            owner_q, owner_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [511:0]             data_q, data_d;
    logic [159:0]             digest_q, digest_d;
    logic                     err_q, err_d;
    logic                     done_q;
    logic                     done_rise;

    logic                     any_req;
    logic [PW-1:0]            pick;
    logic [PW:0]              scan;
    logic [NUM_REQ*512-1:0]   req_shift;

    // Only a fresh rising edge of done counts; a level already high does not.
    assign done_rise = core_done & ~done_q;

    // First requesting index at or above the round-robin pointer, with wrap.
    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        scan    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_q} + (PW+1)'(k);
            if (scan >= (PW+1)'(NUM_REQ)) begin
                scan = scan - (PW+1)'(NUM_REQ);
            end
            if (!any_req && req[scan[PW-1:0]]) begin
                any_req = 1'b1;
                pick    = scan[PW-1:0];
            end
        end
    end

    assign req_shift = req_data >> {pick, 9'd0};

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            rr_q     <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            digest_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            digest_q <= digest_d;
            err_q    <= err_d;
            done_q   <= core_done;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        digest_d = digest_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_START;
                    owner_d = pick;
                    rr_d    = (pick == PW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
                    data_d  = req_shift[511:0];
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CW'(START_CYCLES - 1)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Completion is tested first so it wins over a same-edge timeout.
                if (done_rise) begin
                    state_d  = S_RESP;
                    digest_d = core_out_data;
                    err_d    = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d  = S_RESP;
                    digest_d = '0;
                    err_d    = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        gnt          = '0;
        resp_valid   = '0;
        busy         = (state_q != S_IDLE);
        core_start   = (state_q == S_START);
        core_in_data = data_q;
        resp_digest  = digest_q;
        resp_err     = err_q;
        if (state_q == S_START && cnt_q == '0) begin
            gnt[owner_q] = 1'b1;
        end
        if (state_q == S_RESP) begin
            resp_valid[owner_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_sha_1_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sha_1_arbiter
// Drives sha_1_arbiter with randomized requester blocks and a scripted sha_1
// stub core; checks grants, response timing, error flag and digests against a
// behavioural SHA-1 function and a round-robin order model.
// -----------------------------------------------------------------------------
module tb_sha_1_arbiter;

    localparam int N  = 4;
    localparam int SC = 2;
    localparam int TO = 16;

    logic               clk;
    logic               reset_n;
    logic [N-1:0]       req;
    logic [N*512-1:0]   req_data;
    logic [N-1:0]       gnt;
    logic [N-1:0]       resp_valid;
    logic [159:0]       resp_digest;
    logic               resp_err;
    logic               busy;
    logic               core_start;
    logic [511:0]       core_in_data;
    logic [159:0]       core_out_data;
    logic               core_done;

    sha_1_arbiter #(
        .NUM_REQ        (N),
        .START_CYCLES   (SC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req),
        .req_data      (req_data),
        .gnt           (gnt),
        .resp_valid    (resp_valid),
        .resp_digest   (resp_digest),
        .resp_err      (resp_err),
        .busy          (busy),
        .core_start    (core_start),
        .core_in_data  (core_in_data),
        .core_out_data (core_out_data),
        .core_done     (core_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference SHA-1 compression of one pre-padded block from the standard IV.
    function automatic logic [159:0] sha1(input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, kk, t;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 80; i++) begin
            t    = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {t[30:0], t[31]};
        end
        a = 32'h67452301; b = 32'hEFCDAB89; c = 32'h98BADCFE;
        d = 32'h10325476; e = 32'hC3D2E1F0;
        for (int i = 0; i < 80; i++) begin
            if (i < 20)      begin f = (b & c) | (~b & d);          kk = 32'h5A827999; end
            else if (i < 40) begin f = b ^ c ^ d;                   kk = 32'h6ED9EBA1; end
            else if (i < 60) begin f = (b & c) | (b & d) | (c & d); kk = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                   kk = 32'hCA62C1D6; end
            t = {a[26:0], a[31:27]} + f + e + kk + w[i];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
        end
        return {a + 32'h67452301, b + 32'hEFCDAB89, c + 32'h98BADCFE,
                d + 32'h10325476, e + 32'hC3D2E1F0};
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic int pick_model(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    // Bench state: requesters, stub core schedule, arbitration model
    logic [N-1:0]     req_s;
    logic [N*512-1:0] rd_s;
    int               jobs_left [N];
    int               k;            // cycles since the grant cycle, -1 when no job
    logic             start_prev;
    bit               cfg_rand;
    bit               cfg_pre;
    int               cfg_drop;
    int               cfg_rise;
    logic             idle_level;
    bit               j_pre;
    int               j_drop;
    int               j_rise;
    int               ptr;
    int               owner;
    bit               outstanding;
    logic [159:0]     exp_dig;
    int               exp_lat;
    bit               exp_err;
    int               glog [$];

    // Stub done level in job cycle kk (grant cycle is 0).
    function automatic logic done_at(input int kk);
        if (j_pre && kk < j_drop) return 1'b1;
        if (j_rise >= 0 && kk >= j_rise) return 1'b1;
        return 1'b0;
    endfunction

    // Response cycle and error from the done schedule: first done rise seen
    // while waiting completes; otherwise the watchdog expires.
    task automatic expect_of(output int lat, output bit err);
        lat = SC + TO;
        err = 1'b1;
        for (int kk = SC; kk < SC + TO; kk++) begin
            if (done_at(kk) && !done_at(kk - 1)) begin
                lat = kk + 1;
                err = 1'b0;
                return;
            end
        end
    endtask

    task automatic tick();
        logic         nd;
        logic [N-1:0] ev;
        int           p;
        if (!reset_n) begin
            k           = -1;
            start_prev  = 1'b0;
            ptr         = 0;
            outstanding = 1'b0;
            core_done   = 1'b0;
            return;
        end
        if (core_start && !start_prev) begin
            k             = 0;
            j_pre         = cfg_pre;
            j_drop        = cfg_drop;
            j_rise        = cfg_rand ? int'($urandom_range(12, 2)) : cfg_rise;
            core_out_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
        end else if (k >= 0) begin
            k++;
        end
        start_prev = core_start;

        if (gnt != '0) begin
            p = pick_model(req_s, ptr);
            if (p < 0) begin
                check("gnt_noreq", gnt, '0);
            end else begin
                ev    = '0;
                ev[p] = 1'b1;
                check("gnt_onehot", gnt, ev);
                check("gnt_cycle", k, 0);
                owner       = p;
                ptr         = (p + 1) % N;
                exp_dig     = sha1(rd_s[p*512 +: 512]);
                outstanding = 1'b1;
                glog.push_back(p);
                expect_of(exp_lat, exp_err);
            end
        end

        if (resp_valid != '0) begin
            if (!outstanding) begin
                check("resp_spurious", resp_valid, '0);
            end else begin
                ev        = '0;
                ev[owner] = 1'b1;
                check("resp_onehot", resp_valid, ev);
                check("resp_latency", k, exp_lat);
                check("resp_err", resp_err, exp_err);
                check("resp_digest", resp_digest, exp_err ? 160'd0 : exp_dig);
                jobs_left[owner]--;
                if (jobs_left[owner] > 0) req_data[owner*512 +: 512] = rand_blk();
                else                      req[owner] = 1'b0;
                outstanding = 1'b0;
            end
            k = -1;
        end

        nd = (k < 0) ? idle_level : done_at(k);
        if (nd && !core_done && k >= 0) core_out_data = sha1(core_in_data);
        core_done = nd;
    endtask

    task automatic step();
        @(posedge clk);
        req_s = req;
        rd_s  = req_data;
        @(negedge clk);
        tick();
    endtask

    task automatic submit(input int i, input int n, input logic [511:0] blk);
        req_data[i*512 +: 512] = blk;
        jobs_left[i]           = n;
        req[i]                 = 1'b1;
    endtask

    task automatic run_quiet(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while ((busy || outstanding || req != '0) && n < budget);
        if (n >= budget) check("wait_bound", {busy, outstanding, req}, '0);
    endtask

    int rise_tab [3] = '{1, SC + TO - 1, SC + TO};
    int exp3     [8] = '{2, 1, 2, 1, 2, 1, 2, 1};
    int n;

    initial begin
        reset_n       = 1'b0;
        req           = '0;
        req_data      = '0;
        core_done     = 1'b0;
        core_out_data = '0;
        cfg_rand      = 1'b1;
        cfg_pre       = 1'b0;
        cfg_drop      = 0;
        cfg_rise      = -1;
        idle_level    = 1'b0;
        j_pre         = 1'b0;
        j_drop        = 0;
        j_rise        = -1;
        owner         = 0;
        exp_dig       = '0;
        exp_lat       = 0;
        exp_err       = 1'b0;
        for (int i = 0; i < N; i++) jobs_left[i] = 0;
        repeat (3) step();
        check("rst_outputs", {gnt, resp_valid, resp_err, busy, core_start}, '0);
        check("rst_digest", resp_digest, '0);
        check("rst_core_in", core_in_data, '0);
        reset_n = 1'b1;

        check("sha1_model_abc", sha1({32'h61626380, 448'd0, 32'h00000018}),
              160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);

        // All four held from reset: served 0,1,2,3
        glog.delete();
        for (int i = 0; i < N; i++) submit(i, 1, rand_blk());
        run_quiet(400);
        check("order_all_n", glog.size(), N);
        for (int i = 0; i < N && i < glog.size(); i++) check($sformatf("order_all_%0d", i), glog[i], i);

        // Known-answer block on requester 0
        glog.delete();
        submit(0, 1, {32'h61626380, 448'd0, 32'h00000018});
        run_quiet(100);
        check("abc_owner", (glog.size() == 1) ? glog[0] : -1, 0);
        check("abc_digest", resp_digest, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);
        check("abc_err", resp_err, 1'b0);

        // Requester 2 then 1 and 2 continuously: alternation
        glog.delete();
        submit(2, 4, rand_blk());
        n = 0;
        while (glog.size() == 0 && n < 50) begin step(); n++; end
        check("alt_first_gnt", glog.size(), 1);
        submit(1, 4, rand_blk());
        run_quiet(800);
        check("alt_n", glog.size(), 8);
        for (int i = 0; i < 8 && i < glog.size(); i++) check($sformatf("alt_%0d", i), glog[i], exp3[i]);

        // Hung core and done-edge boundary cases
        cfg_rand = 1'b0;
        cfg_pre  = 1'b0;
        cfg_rise = -1;
        submit(3, 1, rand_blk());
        run_quiet(100);
        check("hang_err", resp_err, 1'b1);
        check("hang_digest", resp_digest, '0);
        for (int i = 0; i < 3; i++) begin
            cfg_rise = rise_tab[i];
            submit(0, 1, rand_blk());
            run_quiet(100);
            check($sformatf("edge_rise_%0d_err", rise_tab[i]), resp_err, (rise_tab[i] == SC + TO - 1) ? 1'b0 : 1'b1);
        end
        cfg_rand = 1'b1;
        submit(1, 1, rand_blk());
        run_quiet(100);
        check("after_hang_err", resp_err, 1'b0);

        // done already high at grant
        cfg_rand   = 1'b0;
        idle_level = 1'b1;
        repeat (2) step();
        cfg_pre  = 1'b1;
        cfg_drop = 1000;
        cfg_rise = -1;
        submit(2, 1, rand_blk());
        run_quiet(100);
        check("prehigh_hold_err", resp_err, 1'b1);
        cfg_drop = SC + 3;
        cfg_rise = SC + 5;
        submit(2, 1, rand_blk());
        run_quiet(100);
        check("prehigh_edge_err", resp_err, 1'b0);
        idle_level = 1'b0;
        cfg_pre    = 1'b0;

        // Reset in the middle of WAIT
        cfg_rise = -1;
        submit(1, 1, rand_blk());
        n = 0;
        while (k != SC + 4 && n < 50) begin step(); n++; end
        check("rst_mid_reached", k, SC + 4);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstmid_outputs", {gnt, resp_valid, resp_err, busy, core_start}, '0);
        check("rstmid_digest", resp_digest, '0);
        check("rstmid_core_in", core_in_data, '0);
        req = '0;
        for (int i = 0; i < N; i++) jobs_left[i] = 0;
        repeat (3) step();
        reset_n  = 1'b1;
        cfg_rand = 1'b1;
        glog.delete();
        submit(0, 1, rand_blk());
        submit(3, 1, rand_blk());
        run_quiet(200);
        check("rstmid_first", (glog.size() > 0) ? glog[0] : -1, 0);
        check("rstmid_n", glog.size(), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
